sum_share_arbiter: RTL

- Shares one pipelined SIZE-lane adder tree between REQS vector requesters.
- Picks a requester round-robin and issues its SIZE-element vector to the tree's lane inputs.
- Records the requester ID in an in-order tag FIFO, then pairs each tree result with its tag on the output stream.
- Sits between the per-neuron input buffers and the single shared sum tree in the network layer.

---
 rtl/sum_share_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sum_share_arbiter.sv
// Round-robin front end for one shared pipelined SIZE-lane sum tree.
// Requester IDs ride an in-order tag FIFO and are re-attached to each returning sum.
module sum_share_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIZE  = 5,
    parameter int unsigned REQS  = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                                        iCLK,
    input  logic                                        iRST,
    input  logic [REQS-1:0]                             iValid_AS,
    output logic [REQS-1:0]                             oReady_AS,
    input  logic [REQS*SIZE*WIDTH-1:0]                  iData_AS,
    output logic [SIZE-1:0]                             oValid_BT,
    input  logic [SIZE-1:0]                             iReady_BT,
    output logic [SIZE*WIDTH-1:0]                       oData_BT,
    input  logic                                        iValid_AT,
    output logic                                        oReady_AT,
    input  logic [$clog2(SIZE)+WIDTH-1:0]               iData_AT,
    output logic                                        oValid_BM,
    input  logic                                        iReady_BM,
    output logic [$clog2(SIZE)+WIDTH-1:0]               oData_BM,
    output logic [((REQS > 1) ? $clog2(REQS) : 1)-1:0]  oTag_BM,
    output logic                                        oBusy,
    output logic                                        oErr
);

    localparam int unsigned TW = (REQS > 1) ? $clog2(REQS) : 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned VW = SIZE * WIDTH;

    typedef enum logic {StEmpty, StFull} issue_state_t;

    issue_state_t   state_q;
    logic [VW-1:0]  vec_q;
    logic [TW-1:0]  rr_ptr_q;
    logic [TW-1:0]  fifo_mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           err_q;

    logic           issue;
    logic           can_accept;
    logic           found;
    logic           accept;
    logic           pop;
    logic [TW-1:0]  grant_idx;
    logic [TW-1:0]  cand;

    assign issue      = (state_q == StFull) && (&iReady_BT);
    assign can_accept = ((state_q == StEmpty) || issue) && (count_q < CW'(DEPTH));

    // First valid requester at or after rr_ptr_q, wrapping modulo REQS.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < int'(REQS); i++) begin
            cand = TW'((32'(rr_ptr_q) + 32'(i)) % REQS);
            if (!found && iValid_AS[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign accept    = can_accept && found;
    assign oReady_AS = accept ? (REQS'(1) << grant_idx) : '0;
    assign pop       = iValid_AT && iReady_BM && (count_q != '0);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= StEmpty;
            vec_q    <= '0;
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                state_q  <= StFull;
                vec_q    <= iData_AS[grant_idx*VW +: VW];
                rr_ptr_q <= (grant_idx == TW'(REQS - 1)) ? '0 : grant_idx + 1'b1;
                wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end else if (issue) begin
                state_q <= StEmpty;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A result with no outstanding tag means the tree and arbiter are out of step.
            if (iValid_AT && (count_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (accept) begin
            fifo_mem[wr_ptr_q] <= grant_idx;
        end
    end

    assign oValid_BT = {SIZE{state_q == StFull}};
    assign oData_BT  = vec_q;
    assign oValid_BM = iValid_AT;
    assign oReady_AT = iReady_BM;
    assign oData_BM  = iData_AT;
    assign oTag_BM   = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;
    assign oBusy     = (count_q != '0);
    assign oErr      = err_q;

endmodule
